// File: rtl/jelly_buffer_requester.sv
// jelly_buffer_requester
// Client-side sequencer for the buffer manager's request/release port.
// A DMA start handshake becomes a single request pulse. The granted address
// and index are captured after a fixed manager latency and held for the frame.
// A done or abort then becomes a single release pulse, and the frame is
// counted in the matching status counter.

`timescale 1ns/1ps

module jelly_buffer_requester #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 2,
    parameter int REQ_LATENCY = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,

    input  logic                   s_start_valid,
    output logic                   s_start_ready,
    input  logic                   s_done,
    input  logic                   s_abort,

    output logic                   m_buf_valid,
    output logic [ADDR_WIDTH-1:0]  m_buf_addr,
    output logic [INDEX_WIDTH-1:0] m_buf_index,

    output logic                   buffer_request,
    output logic                   buffer_release,
    input  logic [ADDR_WIDTH-1:0]  buffer_addr,
    input  logic [INDEX_WIDTH-1:0] buffer_index,

    output logic                   status_busy,
    output logic [COUNT_WIDTH-1:0] status_frame_count,
    output logic [COUNT_WIDTH-1:0] status_abort_count
);

    // The wait counter must hold REQ_LATENCY itself, so it needs one extra code.
    localparam int                    WAIT_WIDTH = $clog2(REQ_LATENCY + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD  = WAIT_WIDTH'(REQ_LATENCY);
    localparam logic [WAIT_WIDTH-1:0] WAIT_ONE   = WAIT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_REL    = 3'd4
    } state_t;

    state_t                 state_q;
    logic [WAIT_WIDTH-1:0]  wait_q;
    logic                   done_q;
    logic                   abort_q;
    logic                   valid_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic                   request_q;
    logic                   release_q;
    logic [COUNT_WIDTH-1:0] frame_count_q;
    logic [COUNT_WIDTH-1:0] abort_count_q;

    // An abort seen in REQ or WAIT stays pending until the grant is released.
    logic                   abort_pending_d;
    logic                   wait_last_d;

    // Combinational helpers for the sequencer; no state is held here.
    always_comb begin
        abort_pending_d = abort_q | s_abort;
        wait_last_d     = (wait_q == WAIT_ONE);
    end

    // Request/wait/active/release sequencer with registered handshake outputs.
    // NOTE: every register here uses non-blocking assignment, so all branches
    // read the pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
            valid_q       <= 1'b0;
            addr_q        <= '0;
            index_q       <= '0;
            request_q     <= 1'b0;
            release_q     <= 1'b0;
            frame_count_q <= '0;
            abort_count_q <= '0;
        end else if (cke) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s_start_valid) begin
                        state_q   <= ST_REQ;
                        request_q <= 1'b1;
                    end
                end

                ST_REQ: begin
                    request_q <= 1'b0;
                    wait_q    <= WAIT_LOAD;
                    abort_q   <= abort_pending_d;
                    state_q   <= ST_WAIT;
                end

                ST_WAIT: begin
                    wait_q  <= wait_q - WAIT_ONE;
                    abort_q <= abort_pending_d;
                    if (wait_last_d) begin
                        // The grant is captured even when aborting, so it is
                        // always handed back through REL exactly once.
                        addr_q  <= buffer_addr;
                        index_q <= buffer_index;
                        if (abort_pending_d) begin
                            release_q <= 1'b1;
                            state_q   <= ST_REL;
                        end else begin
                            valid_q <= 1'b1;
                            state_q <= ST_ACTIVE;
                        end
                    end
                end

                ST_ACTIVE: begin
                    // Abort takes priority over a simultaneous done.
                    if (s_abort) begin
                        abort_q   <= 1'b1;
                        valid_q   <= 1'b0;
                        release_q <= 1'b1;
                        state_q   <= ST_REL;
                    end else if (s_done) begin
                        done_q    <= 1'b1;
                        valid_q   <= 1'b0;
                        release_q <= 1'b1;
                        state_q   <= ST_REL;
                    end
                end

                ST_REL: begin
                    release_q <= 1'b0;
                    if (done_q) begin
                        frame_count_q <= frame_count_q + 1'b1;
                    end else begin
                        abort_count_q <= abort_count_q + 1'b1;
                    end
                    done_q  <= 1'b0;
                    abort_q <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    request_q <= 1'b0;
                    release_q <= 1'b0;
                    valid_q   <= 1'b0;
                    done_q    <= 1'b0;
                    abort_q   <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Only the ready and busy flags are decoded from state; all other outputs are registers.
    assign s_start_ready      = (state_q == ST_IDLE);
    assign status_busy        = (state_q != ST_IDLE);
    assign m_buf_valid        = valid_q;
    assign m_buf_addr         = addr_q;
    assign m_buf_index        = index_q;
    assign buffer_request     = request_q;
    assign buffer_release     = release_q;
    assign status_frame_count = frame_count_q;
    assign status_abort_count = abort_count_q;

endmodule
